// File: rtl/metric_memory_ctrl.sv
// Stage sequencer for the ping-pong Viterbi path-metric memory: walks 16 write
// words per trellis stage, handshakes each stage with the ACS front end.
module metric_memory_ctrl #(
   parameter int FRAME_W     = 12,
   parameter int STAGE_WORDS = 16
) (
   input  logic               Clock1,
   input  logic               Reset,
   input  logic               start,
   input  logic [FRAME_W-1:0] frame_len,
   input  logic               abort,
   input  logic               sym_valid,
   output logic               sym_ready,
   output logic               Active,
   output logic               MMBlockSelect,
   output logic [3:0]         MMWriteAddress,
   output logic [2:0]         MMReadAddress,
   output logic [5:0]         Page,
   output logic               busy,
   output logic               stage_done,
   output logic               frame_done,
   output logic               tb_start,
   output logic [1:0]         fsm_state
);

   // Handshake: a stage is accepted on the rising edge where sym_valid and
   // sym_ready are both high; sym_ready is a pure decode of WAIT_SYM.

   typedef enum logic [1:0] {IDLE, WAIT_SYM, RUN, END} state_t;

   localparam logic [3:0] LAST_WORD = 4'(STAGE_WORDS - 1);
   localparam logic [5:0] PAGE_MAX  = 6'd63;

   state_t             state, state_next;
   logic [3:0]         word_cnt;
   logic [FRAME_W-1:0] stage_cnt;
   logic [FRAME_W-1:0] len_q;
   logic [FRAME_W-1:0] stage_inc;
   logic               last_stage;
   logic               take_start;
   logic               take_sym;
   logic               finish_stage;

   assign stage_inc  = stage_cnt + FRAME_W'(1);
   assign last_stage = (stage_inc == len_q);
   assign sym_ready  = (state == WAIT_SYM);
   assign fsm_state  = state;

   always_comb begin
      state_next   = state;
      take_start   = 1'b0;
      take_sym     = 1'b0;
      finish_stage = 1'b0;
      case (state)
         IDLE: begin
            if (start && (frame_len != '0)) begin
               state_next = WAIT_SYM;
               take_start = 1'b1;
            end
         end
         WAIT_SYM: begin
            if (sym_valid) begin
               state_next = RUN;
               take_sym   = 1'b1;
            end
         end
         RUN: begin
            if (word_cnt == LAST_WORD) state_next = END;
         end
         END: begin
            finish_stage = 1'b1;
            state_next   = last_stage ? IDLE : WAIT_SYM;
         end
         default: state_next = IDLE;
      endcase
      // abort overrides every transition and suppresses all side effects
      if (abort) begin
         state_next   = IDLE;
         take_start   = 1'b0;
         take_sym     = 1'b0;
         finish_stage = 1'b0;
      end
   end

   always_ff @(posedge Clock1) begin
      if (!Reset) begin
         state          <= IDLE;
         word_cnt       <= '0;
         stage_cnt      <= '0;
         len_q          <= '0;
         Active         <= 1'b0;
         MMBlockSelect  <= 1'b0;
         MMWriteAddress <= '0;
         MMReadAddress  <= '0;
         Page           <= '0;
         busy           <= 1'b0;
         stage_done     <= 1'b0;
         frame_done     <= 1'b0;
         tb_start       <= 1'b0;
      end else begin
         state      <= state_next;
         busy       <= (state_next != IDLE);
         Active     <= (state == RUN) && !abort;
         stage_done <= finish_stage;
         frame_done <= finish_stage && last_stage;
         tb_start   <= finish_stage && last_stage;

         if (state == RUN) begin
            MMWriteAddress <= word_cnt;
            MMReadAddress  <= word_cnt[3:1];
            word_cnt       <= word_cnt + 4'd1;
         end

         if (take_sym) word_cnt <= '0;

         if (take_start) begin
            len_q         <= frame_len;
            stage_cnt     <= '0;
            Page          <= '0;
            MMBlockSelect <= 1'b0;
         end

         // Page/block advance land together with stage_done, after the last write
         if (finish_stage) begin
            MMBlockSelect <= ~MMBlockSelect;
            stage_cnt     <= stage_inc;
            if (Page != PAGE_MAX) Page <= Page + 6'd1;
         end
      end
   end

endmodule
